// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [3:0] FETCH_MASK = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and downstream memory handshakes around the arbiter.
interface mem_arbiter_if;

  // fetch requester
  logic        i_imem_req;
  logic [31:0] i_imem_addr;
  logic        o_imem_ready;
  logic        o_imem_valid;
  logic [31:0] o_imem_rdata;

  // data requester
  logic        i_dmem_req;
  logic [31:0] i_dmem_addr;
  logic        i_dmem_ren;
  logic        i_dmem_wen;
  logic [31:0] i_dmem_wdata;
  logic [3:0]  i_dmem_mask;
  logic        o_dmem_ready;
  logic        o_dmem_valid;
  logic [31:0] o_dmem_rdata;

  // downstream memory
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready;
  logic        i_mem_valid;
  logic [31:0] i_mem_rdata;

  // arbiter side
  modport slave (
    input  i_imem_req, i_imem_addr,
    output o_imem_ready, o_imem_valid, o_imem_rdata,
    input  i_dmem_req, i_dmem_addr, i_dmem_ren, i_dmem_wen, i_dmem_wdata, i_dmem_mask,
    output o_dmem_ready, o_dmem_valid, o_dmem_rdata,
    output o_mem_req, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
    input  i_mem_ready, i_mem_valid, i_mem_rdata
  );

  // hart / memory-model side
  modport master (
    output i_imem_req, i_imem_addr,
    input  o_imem_ready, o_imem_valid, o_imem_rdata,
    output i_dmem_req, i_dmem_addr, i_dmem_ren, i_dmem_wen, i_dmem_wdata, i_dmem_mask,
    input  o_dmem_ready, o_dmem_valid, o_dmem_rdata,
    input  o_mem_req, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
    output i_mem_ready, i_mem_valid, i_mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_streak_counter.sv
// Priority decision between fetch and data requesters, with a saturating
// streak counter that forces a fetch grant after MAX_DSTREAK data wins.
module arb_streak_counter #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic idle_i,
  input  logic imem_req_i,
  input  logic dmem_req_i,
  output logic grant_i_o,
  output logic grant_d_o
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DSTREAK);

  logic [3:0] streak_q;
  logic       sat;

  assign sat       = (streak_q == MAX_STREAK);
  assign grant_d_o = idle_i & dmem_req_i & ~(imem_req_i & sat);
  assign grant_i_o = idle_i & imem_req_i & ~grant_d_o;

  // Count data grants that overtook a waiting fetch; only IDLE cycles matter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else if (idle_i) begin
      if (grant_i_o || !imem_req_i) begin
        streak_q <= '0;
      end else if (grant_d_o && !sat) begin
        streak_q <= streak_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one handshaked memory port between fetch and data requesters,
// one outstanding transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus
);

  state_t      state_q;
  owner_t      owner_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        ren_q;
  logic        wen_q;
  logic [31:0] rdata_q;

  logic idle;
  logic issue;
  logic grant_i;
  logic grant_d;
  // Reads are decoded from wen alone, so ren carries no information here.
  logic unused_ren;

  assign idle       = (state_q == IDLE);
  assign issue      = (state_q == ISSUE);
  assign unused_ren = bus.i_dmem_ren;

  arb_streak_counter #(
    .MAX_DSTREAK (MAX_DSTREAK)
  ) u_streak (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .idle_i     (idle),
    .imem_req_i (bus.i_imem_req),
    .dmem_req_i (bus.i_dmem_req),
    .grant_i_o  (grant_i),
    .grant_d_o  (grant_d)
  );

  assign bus.o_imem_ready = grant_i;
  assign bus.o_dmem_ready = grant_d;
  assign bus.o_imem_valid = (state_q == RESP) && (owner_q == OWN_I);
  assign bus.o_dmem_valid = (state_q == RESP) && (owner_q == OWN_D);
  assign bus.o_imem_rdata = rdata_q;
  assign bus.o_dmem_rdata = rdata_q;

  assign bus.o_mem_req   = issue;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_ren   = ren_q & issue;
  assign bus.o_mem_wen   = wen_q & issue;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_mask  = mask_q;

  // Transaction FSM: capture winner, issue downstream, await response, pulse valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            owner_q <= OWN_D;
            addr_q  <= bus.i_dmem_addr;
            wdata_q <= bus.i_dmem_wdata;
            mask_q  <= bus.i_dmem_mask;
            wen_q   <= bus.i_dmem_wen;
            ren_q   <= ~bus.i_dmem_wen;
            state_q <= ISSUE;
          end else if (grant_i) begin
            owner_q <= OWN_I;
            addr_q  <= bus.i_imem_addr;
            wdata_q <= '0;
            mask_q  <= FETCH_MASK;
            wen_q   <= 1'b0;
            ren_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.i_mem_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (bus.i_mem_valid) begin
            rdata_q <= bus.i_mem_rdata;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants,
// downstream requests and responses; a monitor pops and compares them.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   cyc = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_DSTREAK(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  bit           exp_grant[$];   // 1 = data, 0 = fetch
  logic [69:0]  exp_mem[$];     // {addr, ren, wen, mask, wdata}
  logic [33:0]  exp_resp[$];    // {check_rdata, is_data, rdata}

  int  rdy_delay = 0;
  bit  stray_en  = 0;
  bit  no_valid  = 0;
  int  stale_tok = 0;
  int  stale_done = 0;
  logic [31:0] resp_a;

  int gd, gi, gtmp, iwait;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0010_0073 : ((a ^ 32'h5A5A_0000) + 32'd7);
  endfunction

  task automatic exp_fetch(input logic [31:0] a);
    exp_grant.push_back(1'b0);
    exp_mem.push_back({a, 1'b1, 1'b0, 4'hF, 32'h0});
    exp_resp.push_back({1'b1, 1'b0, model(a)});
  endtask

  task automatic exp_load(input logic [31:0] a, input logic [3:0] m, input logic [31:0] wd);
    exp_grant.push_back(1'b1);
    exp_mem.push_back({a, 1'b1, 1'b0, m, wd});
    exp_resp.push_back({1'b1, 1'b1, model(a)});
  endtask

  task automatic exp_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] wd);
    exp_grant.push_back(1'b1);
    exp_mem.push_back({a, 1'b0, 1'b1, m, wd});
    exp_resp.push_back({1'b0, 1'b1, 32'h0});
  endtask

  task automatic req_i(input logic [31:0] a, output int gcyc);
    int n = 0;
    @(posedge clk); #1;
    bus.i_imem_addr = a;
    bus.i_imem_req  = 1'b1;
    @(negedge clk);
    while (!bus.o_imem_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_imem_ready) begin
      tests++; fails++;
      $display("FAIL imem_grant_timeout: addr %0h not granted in %0d cycles", a, n);
    end
    gcyc  = cyc;
    iwait = n;
    @(posedge clk); #1;
    bus.i_imem_req = 1'b0;
  endtask

  task automatic req_d(input logic [31:0] a, input logic ren, input logic wen,
                       input logic [3:0] m, input logic [31:0] wd, output int gcyc);
    int n = 0;
    @(posedge clk); #1;
    bus.i_dmem_addr  = a;
    bus.i_dmem_ren   = ren;
    bus.i_dmem_wen   = wen;
    bus.i_dmem_mask  = m;
    bus.i_dmem_wdata = wd;
    bus.i_dmem_req   = 1'b1;
    @(negedge clk);
    while (!bus.o_dmem_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_dmem_ready) begin
      tests++; fails++;
      $display("FAIL dmem_grant_timeout: addr %0h not granted in %0d cycles", a, n);
    end
    gcyc = cyc;
    @(posedge clk); #1;
    bus.i_dmem_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_grant.size() != 0 || exp_mem.size() != 0 || exp_resp.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      tests++; fails++;
      $display("FAIL drain_timeout: grants %0d mem %0d resp %0d still pending",
               exp_grant.size(), exp_mem.size(), exp_resp.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Downstream memory model
  initial begin
    bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b0;
    bus.i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (stale_tok != stale_done) begin
        stale_done = stale_tok;
        bus.i_mem_valid = 1'b1;
        bus.i_mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.i_mem_valid = 1'b0;
      end else if (bus.o_mem_req) begin
        resp_a = bus.o_mem_addr;
        for (int k = 0; k < rdy_delay; k++) begin
          bus.i_mem_valid = stray_en && (k == 2);
          bus.i_mem_rdata = 32'hBAD0_0000;
          @(negedge clk);
        end
        bus.i_mem_valid = 1'b0;
        bus.i_mem_ready = 1'b1;
        @(negedge clk);
        bus.i_mem_ready = 1'b0;
        if (!no_valid) begin
          bus.i_mem_valid = 1'b1;
          bus.i_mem_rdata = model(resp_a);
          @(negedge clk);
          bus.i_mem_valid = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard
  logic        prev_req = 1'b0;
  logic [69:0] cur_exp  = '0;
  logic [69:0] cur;
  logic [33:0] er;
  bit          eg;

  initial begin
    forever begin
      @(negedge clk);
      cur = {bus.o_mem_addr, bus.o_mem_ren, bus.o_mem_wen, bus.o_mem_mask, bus.o_mem_wdata};

      if (bus.o_imem_ready || bus.o_dmem_ready) begin
        if (exp_grant.size() == 0) begin
          tests++; fails++;
          $display("FAIL grant_unexpected: got ready {d,i}=%b%b expected none",
                   bus.o_dmem_ready, bus.o_imem_ready);
        end else begin
          eg = exp_grant.pop_front();
          check("grant_order", {bus.o_dmem_ready, bus.o_imem_ready}, eg ? 2'b10 : 2'b01);
        end
      end

      if (bus.o_mem_req && !prev_req) begin
        if (exp_mem.size() == 0) begin
          tests++; fails++;
          $display("FAIL mem_req_unexpected: got %0h expected none", cur);
        end else begin
          cur_exp = exp_mem.pop_front();
          check("mem_req", cur, cur_exp);
        end
      end else if (bus.o_mem_req) begin
        check("mem_hold", cur, cur_exp);
      end
      prev_req = bus.o_mem_req;

      if (bus.o_imem_valid || bus.o_dmem_valid) begin
        check("ready_valid_excl", {bus.o_imem_ready & bus.o_imem_valid,
                                   bus.o_dmem_ready & bus.o_dmem_valid}, 2'b00);
        if (exp_resp.size() == 0) begin
          tests++; fails++;
          $display("FAIL resp_unexpected: got valid {d,i}=%b%b expected none",
                   bus.o_dmem_valid, bus.o_imem_valid);
        end else begin
          er = exp_resp.pop_front();
          check("resp_owner", {bus.o_dmem_valid, bus.o_imem_valid}, er[32] ? 2'b10 : 2'b01);
          if (er[33])
            check("resp_rdata", er[32] ? bus.o_dmem_rdata : bus.o_imem_rdata, er[31:0]);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    rst = 1'b1;
    bus.i_imem_req   = 1'b0;
    bus.i_imem_addr  = '0;
    bus.i_dmem_req   = 1'b0;
    bus.i_dmem_addr  = '0;
    bus.i_dmem_ren   = 1'b0;
    bus.i_dmem_wen   = 1'b0;
    bus.i_dmem_wdata = '0;
    bus.i_dmem_mask  = '0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_ctrl", {bus.o_imem_ready, bus.o_imem_valid, bus.o_dmem_ready, bus.o_dmem_valid,
                       bus.o_mem_req, bus.o_mem_ren, bus.o_mem_wen}, 7'b0);
    check("rst_regs", {bus.o_mem_addr, bus.o_mem_mask, bus.o_mem_wdata}, 68'h0);
    check("rst_rdata", {bus.o_imem_rdata, bus.o_dmem_rdata}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single fetch with minimum latency
    exp_fetch(32'h100);
    req_i(32'h100, gtmp);
    check("fetch_ready_c0", iwait, 0);
    @(negedge clk);
    check("fetch_req_c1", {bus.o_mem_req, bus.o_mem_addr, bus.o_mem_mask}, {1'b1, 32'h100, 4'hF});
    @(negedge clk);
    check("fetch_novalid_c2", bus.o_imem_valid, 1'b0);
    @(negedge clk);
    check("fetch_valid_c3", {bus.o_imem_valid, bus.o_imem_rdata}, {1'b1, 32'h0010_0073});
    wait_drain();

    // tie: data first, fetch in the IDLE cycle after data RESP
    exp_load(32'h2000, 4'b1100, 32'h1111_1111);
    exp_fetch(32'h104);
    fork
      req_d(32'h2000, 1'b1, 1'b0, 4'b1100, 32'h1111_1111, gd);
      req_i(32'h104, gi);
    join
    check("tie_gap", gi - gd, 4);
    wait_drain();

    // read decode with ren=0
    exp_load(32'h2010, 4'b0011, 32'h0);
    req_d(32'h2010, 1'b0, 1'b0, 4'b0011, 32'h0, gtmp);
    wait_drain();

    // starvation: D,D,D,D,I,D,D,D,D,I
    for (int k = 0; k < 10; k++) begin
      if (k == 4)      exp_fetch(32'h200);
      else if (k == 9) exp_fetch(32'h204);
      else             exp_load(32'h3000 + 32'((k < 4 ? k : k - 1) * 4), 4'hF, 32'((k < 4 ? k : k - 1)));
    end
    fork
      begin
        for (int k = 0; k < 8; k++) req_d(32'h3000 + 32'(k * 4), 1'b1, 1'b0, 4'hF, 32'(k), gd);
      end
      begin
        for (int k = 0; k < 2; k++) req_i(32'h200 + 32'(k * 4), gi);
      end
    join
    wait_drain();

    // store with ren also set
    exp_store(32'h2003, 4'b1000, 32'hAB00_0000);
    req_d(32'h2003, 1'b1, 1'b1, 4'b1000, 32'hAB00_0000, gtmp);
    wait_drain();

    // backpressure with a stray valid during ISSUE
    rdy_delay = 5;
    stray_en  = 1'b1;
    exp_fetch(32'h400);
    req_i(32'h400, gtmp);
    wait_drain();
    rdy_delay = 0;
    stray_en  = 1'b0;

    // asynchronous reset mid-WAIT
    no_valid = 1'b1;
    exp_grant.push_back(1'b1);
    exp_mem.push_back({32'h5000, 1'b1, 1'b0, 4'hF, 32'h0});
    req_d(32'h5000, 1'b1, 1'b0, 4'hF, 32'h0, gtmp);
    @(negedge clk);   // ISSUE, model raises ready
    @(negedge clk);   // WAIT
    #2;
    rst = 1'b1;
    #1;
    check("arst_ctrl", {bus.o_imem_ready, bus.o_imem_valid, bus.o_dmem_ready, bus.o_dmem_valid,
                        bus.o_mem_req, bus.o_mem_ren, bus.o_mem_wen}, 7'b0);
    check("arst_regs", {bus.o_mem_addr, bus.o_mem_mask, bus.o_mem_wdata}, 68'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    no_valid = 1'b0;
    stale_tok++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("arst_no_valid", {bus.o_imem_valid, bus.o_dmem_valid}, 2'b00);
    end

    // recovery after reset
    exp_fetch(32'h500);
    req_i(32'h500, gtmp);
    wait_drain();

    check("queues_empty", {exp_grant.size(), exp_mem.size(), exp_resp.size()}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
